// File: rtl/nanosoc_bootrom_ahb_gate.sv
// AHB-Lite gate in front of the CPU 0 bootrom: forwards legal reads, answers the rest with ERROR.
// Optional statistics ports ERR_COUNT/ERR_ADDR are built when NANOSOC_BOOTROM_GATE_STATS_EN is defined.
module nanosoc_bootrom_ahb_gate #(
  parameter int SYS_DATA_W     = 32,
  parameter int BOOTROM_ADDR_W = 10
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      HSELS,
  input  logic [BOOTROM_ADDR_W-1:0] HADDRS,
  input  logic [1:0]                HTRANSS,
  input  logic [2:0]                HSIZES,
  input  logic                      HWRITES,
  input  logic [SYS_DATA_W-1:0]     HWDATAS,
  input  logic                      HREADYS,
  output logic                      HREADYOUTS,
  output logic [SYS_DATA_W-1:0]     HRDATAS,
  output logic                      HRESPS,
  output logic                      HSELM,
  output logic [BOOTROM_ADDR_W-1:0] HADDRM,
  output logic [1:0]                HTRANSM,
  output logic [2:0]                HSIZEM,
  output logic                      HWRITEM,
  output logic                      HREADYM,
  input  logic                      HREADYOUTM,
  input  logic [SYS_DATA_W-1:0]     HRDATAM,
  input  logic                      HRESPM,
  input  logic                      BOOT_LOCK,
  output logic                      LOCKED
`ifdef NANOSOC_BOOTROM_GATE_STATS_EN
  ,
  output logic [7:0]                ERR_COUNT,
  output logic [BOOTROM_ADDR_W-1:0] ERR_ADDR
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FWD,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   locked_q;
  logic   accept;
  logic   size_bad;
  logic   align_bad;
  logic   reject;
  logic   unused_wdata;

  // The bootrom is read-only, so write data is never looked at.
  assign unused_wdata = ^HWDATAS;

  assign accept    = HSELS & HTRANSS[1] & HREADYS;
  assign size_bad  = (HSIZES > 3'd2);
  assign align_bad = ((HSIZES == 3'd2) && (HADDRS[1:0] != 2'b00)) ||
                     ((HSIZES == 3'd1) && HADDRS[0]);
  assign reject    = HWRITES | size_bad | align_bad | locked_q;

  assign HSELM   = HSELS & ~reject;
  assign HADDRM  = HADDRS;
  assign HTRANSM = HTRANSS;
  assign HSIZEM  = HSIZES;
  assign HWRITEM = 1'b0;
  assign HREADYM = HREADYS;
  assign LOCKED  = locked_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      locked_q <= locked_q | BOOT_LOCK;
    end
  end

  // ERR1 always advances; a stalled bootrom holds FWD; otherwise a ready bus samples a new address phase.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end else if ((state_q == ST_FWD) && !HREADYOUTM) begin
      state_d = ST_FWD;
    end else if (HREADYS) begin
      if (accept && !reject) begin
        state_d = ST_FWD;
      end else if (accept) begin
        state_d = ST_ERR1;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_comb begin
    HREADYOUTS = 1'b1;
    HRESPS     = 1'b0;
    HRDATAS    = '0;
    case (state_q)
      ST_FWD: begin
        HREADYOUTS = HREADYOUTM;
        HRESPS     = HRESPM;
        HRDATAS    = HRDATAM;
      end
      ST_ERR1: begin
        HREADYOUTS = 1'b0;
        HRESPS     = 1'b1;
      end
      ST_ERR2: begin
        HREADYOUTS = 1'b1;
        HRESPS     = 1'b1;
      end
      default: begin
        HREADYOUTS = 1'b1;
        HRESPS     = 1'b0;
      end
    endcase
  end

`ifdef NANOSOC_BOOTROM_GATE_STATS_EN
  logic [7:0]                err_count_q;
  logic [BOOTROM_ADDR_W-1:0] err_addr_q;

  // ERR1 lasts exactly one cycle, so every cycle heading into it is a fresh entry.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_count_q <= 8'h00;
      err_addr_q  <= '0;
    end else if (state_d == ST_ERR1) begin
      if (err_count_q != 8'hFF) begin
        err_count_q <= err_count_q + 8'h01;
      end
      err_addr_q <= HADDRS;
    end
  end

  assign ERR_COUNT = err_count_q;
  assign ERR_ADDR  = err_addr_q;
`else
  // Statistics disabled: no error counter or address capture is built.
`endif

endmodule

// File: tb/tb_nanosoc_bootrom_ahb_gate.sv
// Directed self-checking bench for nanosoc_bootrom_ahb_gate; the matrix ready loop is closed via HREADYS = HREADYOUTS.
module tb_nanosoc_bootrom_ahb_gate;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSELS;
  logic [9:0]  HADDRS;
  logic [1:0]  HTRANSS;
  logic [2:0]  HSIZES;
  logic        HWRITES;
  logic [31:0] HWDATAS;
  logic        HREADYS;
  logic        HREADYOUTS;
  logic [31:0] HRDATAS;
  logic        HRESPS;
  logic        HSELM;
  logic [9:0]  HADDRM;
  logic [1:0]  HTRANSM;
  logic [2:0]  HSIZEM;
  logic        HWRITEM;
  logic        HREADYM;
  logic        HREADYOUTM;
  logic [31:0] HRDATAM;
  logic        HRESPM;
  logic        BOOT_LOCK;
  logic        LOCKED;
`ifdef NANOSOC_BOOTROM_GATE_STATS_EN
  logic [7:0]  ERR_COUNT;
  logic [9:0]  ERR_ADDR;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 HCLK = ~HCLK;

  assign HREADYS = HREADYOUTS;

  nanosoc_bootrom_ahb_gate #(
    .SYS_DATA_W     (32),
    .BOOTROM_ADDR_W (10)
  ) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .HSELS      (HSELS),
    .HADDRS     (HADDRS),
    .HTRANSS    (HTRANSS),
    .HSIZES     (HSIZES),
    .HWRITES    (HWRITES),
    .HWDATAS    (HWDATAS),
    .HREADYS    (HREADYS),
    .HREADYOUTS (HREADYOUTS),
    .HRDATAS    (HRDATAS),
    .HRESPS     (HRESPS),
    .HSELM      (HSELM),
    .HADDRM     (HADDRM),
    .HTRANSM    (HTRANSM),
    .HSIZEM     (HSIZEM),
    .HWRITEM    (HWRITEM),
    .HREADYM    (HREADYM),
    .HREADYOUTM (HREADYOUTM),
    .HRDATAM    (HRDATAM),
    .HRESPM     (HRESPM),
    .BOOT_LOCK  (BOOT_LOCK),
    .LOCKED     (LOCKED)
`ifdef NANOSOC_BOOTROM_GATE_STATS_EN
    ,
    .ERR_COUNT  (ERR_COUNT),
    .ERR_ADDR   (ERR_ADDR)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic sel, input logic [1:0] trans, input logic [9:0] addr,
                               input logic [2:0] size, input logic write);
    HSELS   = sel;
    HTRANSS = trans;
    HADDRS  = addr;
    HSIZES  = size;
    HWRITES = write;
    HWDATAS = 32'hDEAD_BEEF;
  endtask

  task automatic nextCycle();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    HRESETn    = 1'b0;
    HREADYOUTM = 1'b1;
    HRDATAM    = 32'h0;
    HRESPM     = 1'b0;
    BOOT_LOCK  = 1'b0;
    applyStimulus(1'b0, 2'b00, 10'h000, 3'd2, 1'b0);
    #12;
    checkOutput("rst_readyout", HREADYOUTS, 1);
    checkOutput("rst_resp", HRESPS, 0);
    checkOutput("rst_rdata", HRDATAS, 0);
    checkOutput("rst_locked", LOCKED, 0);
    HRESETn = 1'b1;

    // Legal word read forwarded, data returned next cycle
    nextCycle();
    applyStimulus(1'b1, 2'b10, 10'h004, 3'd2, 1'b0);
    #1;
    checkOutput("rd004_hselm", HSELM, 1);
    checkOutput("rd004_haddrm", HADDRM, 10'h004);
    checkOutput("rd004_hwritem", HWRITEM, 0);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 10'h000, 3'd2, 1'b0);
    HRDATAM = 32'hA5A5_0004;
    #1;
    checkOutput("rd004_rdata", HRDATAS, 32'hA5A5_0004);
    checkOutput("rd004_resp", HRESPS, 0);
    checkOutput("rd004_ready", HREADYOUTS, 1);

    // Write rejected with two-cycle ERROR
    nextCycle();
    applyStimulus(1'b1, 2'b10, 10'h010, 3'd2, 1'b1);
    #1;
    checkOutput("wr010_hselm", HSELM, 0);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 10'h000, 3'd2, 1'b0);
    #1;
    checkOutput("wr010_err1_ready", HREADYOUTS, 0);
    checkOutput("wr010_err1_resp", HRESPS, 1);
    checkOutput("wr010_err1_rdata", HRDATAS, 0);
    nextCycle();
    checkOutput("wr010_err2_ready", HREADYOUTS, 1);
    checkOutput("wr010_err2_resp", HRESPS, 1);
`ifdef NANOSOC_BOOTROM_GATE_STATS_EN
    checkOutput("wr010_errcount", ERR_COUNT, 1);
    checkOutput("wr010_erraddr", ERR_ADDR, 10'h010);
`endif
    nextCycle();
    checkOutput("wr010_idle_resp", HRESPS, 0);

    // Misaligned word read rejected, halfword read at same address forwarded back-to-back
    applyStimulus(1'b1, 2'b10, 10'h002, 3'd2, 1'b0);
    #1;
    checkOutput("rd002w_hselm", HSELM, 0);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 10'h000, 3'd2, 1'b0);
    #1;
    checkOutput("rd002w_err1_ready", HREADYOUTS, 0);
    checkOutput("rd002w_err1_resp", HRESPS, 1);
    nextCycle();
    applyStimulus(1'b1, 2'b10, 10'h002, 3'd1, 1'b0);
    #1;
    checkOutput("rd002w_err2_ready", HREADYOUTS, 1);
    checkOutput("rd002w_err2_resp", HRESPS, 1);
    checkOutput("rd002h_hselm", HSELM, 1);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 10'h000, 3'd2, 1'b0);
    HRDATAM = 32'h0000_BEEF;
    #1;
    checkOutput("rd002h_resp", HRESPS, 0);
    checkOutput("rd002h_ready", HREADYOUTS, 1);
    checkOutput("rd002h_rdata", HRDATAS, 32'h0000_BEEF);

    // Back-to-back reads 0x000, 0x004, 0x008
    nextCycle();
    applyStimulus(1'b1, 2'b10, 10'h000, 3'd2, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 2'b10, 10'h004, 3'd2, 1'b0);
    HRDATAM = 32'h1111_0000;
    #1;
    checkOutput("b2b0_rdata", HRDATAS, 32'h1111_0000);
    checkOutput("b2b0_ready", HREADYOUTS, 1);
    nextCycle();
    applyStimulus(1'b1, 2'b10, 10'h008, 3'd2, 1'b0);
    HRDATAM = 32'h2222_0004;
    #1;
    checkOutput("b2b4_rdata", HRDATAS, 32'h2222_0004);
    checkOutput("b2b4_resp", HRESPS, 0);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 10'h000, 3'd2, 1'b0);
    HRDATAM = 32'h3333_0008;
    #1;
    checkOutput("b2b8_rdata", HRDATAS, 32'h3333_0008);
    checkOutput("b2b8_ready", HREADYOUTS, 1);
    nextCycle();
    checkOutput("b2b_idle_rdata", HRDATAS, 0);

    // Bootrom wait state stretches the forwarded data phase
    applyStimulus(1'b1, 2'b10, 10'h014, 3'd2, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 10'h000, 3'd2, 1'b0);
    HREADYOUTM = 1'b0;
    #1;
    checkOutput("wait_ready_low", HREADYOUTS, 0);
    nextCycle();
    HREADYOUTM = 1'b1;
    HRDATAM    = 32'h4444_0014;
    #1;
    checkOutput("wait_ready_high", HREADYOUTS, 1);
    checkOutput("wait_rdata", HRDATAS, 32'h4444_0014);

    // BOOT_LOCK during the data phase of read 0x00C
    nextCycle();
    applyStimulus(1'b1, 2'b10, 10'h00C, 3'd2, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 10'h000, 3'd2, 1'b0);
    BOOT_LOCK = 1'b1;
    HRDATAM   = 32'h5555_000C;
    #1;
    checkOutput("lock_rd00c_rdata", HRDATAS, 32'h5555_000C);
    checkOutput("lock_rd00c_resp", HRESPS, 0);
    checkOutput("lock_before_edge", LOCKED, 0);
    nextCycle();
    BOOT_LOCK = 1'b0;
    applyStimulus(1'b1, 2'b10, 10'h000, 3'd2, 1'b0);
    #1;
    checkOutput("lock_set", LOCKED, 1);
    checkOutput("lock_rd000_hselm", HSELM, 0);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 10'h000, 3'd2, 1'b0);
    #1;
    checkOutput("lock_rd000_err1_resp", HRESPS, 1);
    checkOutput("lock_rd000_err1_ready", HREADYOUTS, 0);
    checkOutput("lock_rd000_rdata", HRDATAS, 0);
    nextCycle();
    checkOutput("lock_rd000_err2_resp", HRESPS, 1);
    nextCycle();
    checkOutput("lock_sticky", LOCKED, 1);
`ifdef NANOSOC_BOOTROM_GATE_STATS_EN
    checkOutput("lock_errcount", ERR_COUNT, 3);
`endif

    // Asynchronous reset while in ERR1
    applyStimulus(1'b1, 2'b10, 10'h020, 3'd2, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 10'h000, 3'd2, 1'b0);
    #1;
    checkOutput("rstmid_err1_ready", HREADYOUTS, 0);
    HRESETn = 1'b0;
    #1;
    checkOutput("rstmid_ready", HREADYOUTS, 1);
    checkOutput("rstmid_resp", HRESPS, 0);
    checkOutput("rstmid_locked", LOCKED, 0);
`ifdef NANOSOC_BOOTROM_GATE_STATS_EN
    checkOutput("rstmid_errcount", ERR_COUNT, 0);
`endif
    #1;
    HRESETn = 1'b1;

    // IDLE transfer with select high: zero-wait OKAY, no forwarded data phase
    nextCycle();
    applyStimulus(1'b1, 2'b00, 10'h004, 3'd2, 1'b0);
    HRDATAM = 32'h6666_0004;
    nextCycle();
    applyStimulus(1'b0, 2'b00, 10'h000, 3'd2, 1'b0);
    #1;
    checkOutput("idletr_ready", HREADYOUTS, 1);
    checkOutput("idletr_resp", HRESPS, 0);
    checkOutput("idletr_rdata", HRDATAS, 0);

    nextCycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
